sync_fifo_param: RTL and testbench

Single-clock, parametrised successor to the team's asynchronous FIFO. It has configurable width and depth, programmable almost-full and almost-empty thresholds, a live fill count, and a selectable read mode (registered read or first-word-fall-through). It is intended for the data paths inside one clock domain, for example buffering between the AXI and APB-side logic, where the dual-clock FIFO is unnecessary.

---
 rtl/sync_fifo_param.sv | 145 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with parametrised width and depth,
// programmable almost-full/almost-empty thresholds, registered occupancy
// flags and a selectable read mode (FWFT=0 registered read, FWFT=1
// first-word-fall-through).
// Optional macro SYNC_FIFO_ERR_EN adds err_clr plus sticky overflow and
// underflow flags.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       we,
    input  logic                       re,
    output logic [WIDTH-1:0]           dataout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic                       err_clr,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W:0]  PTR_ONE = 1;
    localparam logic [CNT_W-1:0] AF_CNT  = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT  = CNT_W'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               af_q, af_d;
    logic               ae_q, ae_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               wr_en, rd_en;

    // Accept decisions use the registered (pre-edge) flags; next pointers,
    // occupancy flags and the read register follow from them.
    always_comb begin
        wr_en    = we && !full_q;
        rd_en    = re && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
        // Pointer difference modulo 2*DEPTH is the occupancy 0..DEPTH.
        count_d = wr_ptr_d - rd_ptr_d;
        full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                  (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        af_d    = (count_d >= AF_CNT);
        ae_d    = (count_d <= AE_CNT);
    end

    // Pointer, occupancy flag and read-data registers with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array: written on accepted writes, never cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= datain;
        end
    end

    // Output data: FWFT shows the head word while non-empty, otherwise the
    // last popped word held in dout_q.
    always_comb begin
        dataout = dout_q;
        if ((FWFT != 0) && !empty_q) begin
            dataout = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; a new set event beats a simultaneous clear.
    always_comb begin
        overflow_d  = (overflow_q  && !err_clr) || (we && full_q);
        underflow_d = (underflow_q && !err_clr) || (re && empty_q);
    end

    // Error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: one registered-read
// instance (a) and one FWFT instance (b), both DEPTH=8, AF=6, AE=2.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, we_a, re_a, full_a, empty_a, af_a, ae_a;
    logic [7:0] din_a, dout_a;
    logic [3:0] cnt_a;
    logic       rst_b, we_b, re_b, full_b, empty_b, af_b, ae_b;
    logic [7:0] din_b, dout_b;
    logic [3:0] cnt_b;
`ifdef SYNC_FIFO_ERR_EN
    logic       clr_a, ovf_a, udf_a, clr_b, ovf_b, udf_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut_a (
        .clk(clk), .reset(rst_a), .datain(din_a), .we(we_a), .re(re_a),
        .dataout(dout_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a)
`ifdef SYNC_FIFO_ERR_EN
        , .err_clr(clr_a), .overflow(ovf_a), .underflow(udf_a)
`endif
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_b (
        .clk(clk), .reset(rst_b), .datain(din_b), .we(we_b), .re(re_b),
        .dataout(dout_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b)
`ifdef SYNC_FIFO_ERR_EN
        , .err_clr(clr_b), .overflow(ovf_b), .underflow(udf_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; we_a = 1'b0; re_a = 1'b0; din_a = '0;
        rst_b = 1'b1; we_b = 1'b0; re_b = 1'b0; din_b = '0;
`ifdef SYNC_FIFO_ERR_EN
        clr_a = 1'b0; clr_b = 1'b0;
`endif
        // 1. reset
        tick; tick;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("rst_empty", empty_a, 1);
        check("rst_full", full_a, 0);
        check("rst_count", cnt_a, 0);
        check("rst_ae", ae_a, 1);
        check("rst_af", af_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_b_empty", empty_b, 1);
        check("rst_b_dout", dout_b, 0);
        tick;
        check("idle_count", cnt_a, 0);

        // 2. fill
        for (int i = 0; i < 8; i++) begin
            we_a = 1'b1; din_a = 8'h10 + 8'(i);
            tick;
            if (i == 1) check("fill_ae2", ae_a, 1);
            if (i == 2) check("fill_ae3", ae_a, 0);
            if (i == 4) begin check("fill_cnt5", cnt_a, 5); check("fill_af5", af_a, 0); end
            if (i == 5) begin check("fill_cnt6", cnt_a, 6); check("fill_af6", af_a, 1); end
            if (i == 6) check("fill_full7", full_a, 0);
        end
        check("fill_full8", full_a, 1);
        check("fill_cnt8", cnt_a, 8);
        din_a = 8'hFF;
        tick;
        we_a = 1'b0;
        check("ovf_cnt", cnt_a, 8);
        check("ovf_full", full_a, 1);
`ifdef SYNC_FIFO_ERR_EN
        check("ovf_flag", ovf_a, 1);
`endif

        // 3. drain
        for (int i = 0; i < 8; i++) begin
            re_a = 1'b1;
            tick;
            check("drain_dout", dout_a, 32'h10 + 32'(i));
            check("drain_cnt", cnt_a, 32'(7 - i));
        end
        check("drain_empty", empty_a, 1);
        tick;
        re_a = 1'b0;
        check("udf_dout", dout_a, 8'h17);
        check("udf_empty", empty_a, 1);
`ifdef SYNC_FIFO_ERR_EN
        check("udf_flag", udf_a, 1);
        clr_a = 1'b1;
        tick;
        check("clr_ovf", ovf_a, 0);
        check("clr_udf", udf_a, 0);
        re_a = 1'b1;
        tick;
        re_a = 1'b0; clr_a = 1'b0;
        check("set_wins", udf_a, 1);
        clr_a = 1'b1;
        tick;
        clr_a = 1'b0;
        check("clr_again", udf_a, 0);
`endif

        // 4. streaming across the pointer wrap at count=4
        for (int i = 0; i < 4; i++) begin
            we_a = 1'b1; din_a = 8'h20 + 8'(i);
            tick;
        end
        we_a = 1'b0;
        check("pre_stream_cnt", cnt_a, 4);
        for (int i = 0; i < 20; i++) begin
            we_a = 1'b1; re_a = 1'b1; din_a = 8'h24 + 8'(i);
            tick;
            check("stream_dout", dout_a, 32'h20 + 32'(i));
            check("stream_cnt", cnt_a, 4);
        end
        we_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            re_a = 1'b1;
            tick;
            check("tail_dout", dout_a, 32'h34 + 32'(i));
        end
        re_a = 1'b0;
        check("tail_empty", empty_a, 1);

        // 5. simultaneous requests at full and at empty
`ifdef SYNC_FIFO_ERR_EN
        clr_a = 1'b1; tick; clr_a = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            we_a = 1'b1; din_a = 8'h40 + 8'(i);
            tick;
        end
        check("b5_full", full_a, 1);
        we_a = 1'b1; re_a = 1'b1; din_a = 8'h48;
        tick;
        we_a = 1'b0; re_a = 1'b0;
        check("full_rw_cnt", cnt_a, 7);
        check("full_rw_full", full_a, 0);
        check("full_rw_dout", dout_a, 8'h40);
`ifdef SYNC_FIFO_ERR_EN
        check("full_rw_ovf", ovf_a, 1);
`endif
        for (int i = 0; i < 7; i++) begin
            re_a = 1'b1;
            tick;
            check("b5_drain", dout_a, 32'h41 + 32'(i));
        end
        re_a = 1'b0;
        check("b5_empty", empty_a, 1);
`ifdef SYNC_FIFO_ERR_EN
        clr_a = 1'b1; tick; clr_a = 1'b0;
`endif
        we_a = 1'b1; re_a = 1'b1; din_a = 8'h50;
        tick;
        we_a = 1'b0; re_a = 1'b0;
        check("empty_rw_cnt", cnt_a, 1);
        check("empty_rw_empty", empty_a, 0);
        check("empty_rw_dout", dout_a, 8'h47);
`ifdef SYNC_FIFO_ERR_EN
        check("empty_rw_udf", udf_a, 1);
`endif
        re_a = 1'b1;
        tick;
        re_a = 1'b0;
        check("last_dout", dout_a, 8'h50);
        check("last_empty", empty_a, 1);

        // 6. FWFT instance
        we_b = 1'b1; din_b = 8'hA5;
        tick;
        we_b = 1'b0;
        check("fwft_empty", empty_b, 0);
        check("fwft_dout", dout_b, 8'hA5);
        check("fwft_cnt", cnt_b, 1);
        re_b = 1'b1;
        tick;
        re_b = 1'b0;
        check("fwft_pop_empty", empty_b, 1);
        check("fwft_pop_hold", dout_b, 8'hA5);
        check("fwft_pop_cnt", cnt_b, 0);
        for (int i = 0; i < 6; i++) begin
            we_b = 1'b1; din_b = 8'hB0 + 8'(i);
            tick;
        end
        we_b = 1'b0;
        check("fwft_head", dout_b, 8'hB0);
        re_b = 1'b1;
        tick;
        re_b = 1'b0;
        check("fwft_next", dout_b, 8'hB1);
        check("fwft_cnt5", cnt_b, 5);
        we_b = 1'b1; re_b = 1'b1; din_b = 8'hC0;
        rst_b = 1'b1;
        #1;
        check("async_cnt", cnt_b, 0);
        check("async_empty", empty_b, 1);
        check("async_full", full_b, 0);
        check("async_dout", dout_b, 0);
        tick;
        check("rst_hold_cnt", cnt_b, 0);
        we_b = 1'b0; re_b = 1'b0;
        rst_b = 1'b0;
        tick;
        check("post_rst_empty", empty_b, 1);
        check("post_rst_cnt", cnt_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
